// File: rtl/assoc_tag_array_pkg.sv
// Shared types for the set-associative tag store: op codes, flush FSM states
// and the per-way entry record.
package assoc_tag_pkg;

   // Widest tag any instance may use; entries store this many bits and
   // narrower instances zero-extend, so the upper flops are constant.
   localparam int TAG_W_MAX = 32;

   typedef enum logic [1:0] {
      OP_LOOKUP = 2'b00,
      OP_FILL   = 2'b01,
      OP_INVAL  = 2'b10
   } op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_e;

   typedef struct packed {
      logic                 valid;
      logic [TAG_W_MAX-1:0] tag;
   } way_ent_t;

endpackage

// File: rtl/assoc_tag_array_if.sv
// Request/response and flush handshake between the cache controller
// (master) and the tag array (slave).
interface assoc_tag_array_if #(
   parameter int SETS  = 64,
   parameter int WAYS  = 2,
   parameter int TAG_W = 6
);
   localparam int SET_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);

   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [SET_W-1:0] req_set;
   logic [TAG_W-1:0] req_tag;
   logic             flush_start;
   logic             busy;
   logic             rsp_valid;
   logic             rsp_hit;
   logic [WAY_W-1:0] rsp_way;
   logic [WAY_W-1:0] rsp_victim;
   logic             rsp_victim_dirty;

   modport master (
      output req_valid, req_op, req_set, req_tag, flush_start,
      input  req_ready, busy, rsp_valid, rsp_hit, rsp_way, rsp_victim,
             rsp_victim_dirty
   );

   modport slave (
      input  req_valid, req_op, req_set, req_tag, flush_start,
      output req_ready, busy, rsp_valid, rsp_hit, rsp_way, rsp_victim,
             rsp_victim_dirty
   );

endinterface

// File: rtl/assoc_tag_array_plru_tree.sv
// Combinational tree pseudo-LRU: walks the tree bits to find the victim and
// computes the bits that result from touching a given way. Tree bits are
// heap-ordered (node k at bit k-1, children 2k and 2k+1); a bit of 1 means
// the victim lies in the right subtree.
module plru_tree #(
   parameter int  WAYS  = 2,
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-2:0]  i_tree,
   input  logic [WAY_W-1:0] i_touch,
   output logic [WAY_W-1:0] o_victim,
   output logic [WAYS-2:0]  o_tree
);

   logic [WAY_W:0]   w_vnode;
   logic [WAY_W:0]   w_unode;
   logic [WAY_W-1:0] w_tw;

   // Follow the tree bits from the root; the leaf index minus WAYS is the victim.
   always_comb begin
      w_vnode = (WAY_W+1)'(1);
      for (int l = 0; l < WAY_W; l++) begin
         w_vnode = {w_vnode[WAY_W-1:0], i_tree[w_vnode[WAY_W-1:0] - WAY_W'(1)]};
      end
      o_victim = w_vnode[WAY_W-1:0];
   end

   // Walk the touched way's path (MSB first) and point every node away from it.
   always_comb begin
      o_tree  = i_tree;
      w_unode = (WAY_W+1)'(1);
      w_tw    = i_touch;
      for (int l = 0; l < WAY_W; l++) begin
         o_tree[w_unode[WAY_W-1:0] - WAY_W'(1)] = ~w_tw[WAY_W-1];
         w_unode = {w_unode[WAY_W-1:0], w_tw[WAY_W-1]};
         w_tw    = w_tw << 1;
      end
   end

endmodule

// File: rtl/assoc_tag_array.sv
// N-way set-associative tag/metadata store with tree pseudo-LRU replacement,
// single-cycle registered responses and a one-set-per-cycle flush sequencer.
module assoc_tag_array
   import assoc_tag_pkg::*;
#(
   parameter int SETS  = 64,
   parameter int WAYS  = 2,
   parameter int TAG_W = 6
) (
   input  logic           clk,
   input  logic           rst,
   assoc_tag_array_if.slave bus
);

   localparam int SET_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);

   // Array state: all flops, indexed by set.
   way_ent_t [WAYS-1:0] r_ways [SETS];
   logic [WAYS-2:0]     r_plru [SETS];

   state_e           r_state;
   logic [SET_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_rsp_valid;
   logic             r_rsp_hit;
   logic [WAY_W-1:0] r_rsp_way;
   logic [WAY_W-1:0] r_rsp_victim;
   logic             r_rsp_dirty;

   logic [TAG_W_MAX-1:0] w_tag;
   way_ent_t [WAYS-1:0]  w_row;
   logic [WAYS-2:0]      w_tree;
   logic [WAYS-2:0]      w_tree_nxt;
   logic                 w_hit;
   logic                 w_any_inv;
   logic [WAY_W-1:0]     w_hit_way;
   logic [WAY_W-1:0]     w_inv_way;
   logic [WAY_W-1:0]     w_plru_victim;
   logic [WAY_W-1:0]     w_victim;
   logic [WAY_W-1:0]     w_touch;
   logic                 w_ready;
   logic                 w_accept;

   assign w_tag  = TAG_W_MAX'(bus.req_tag);
   assign w_row  = r_ways[bus.req_set];
   assign w_tree = r_plru[bus.req_set];

   // Tag match and lowest invalid way; descending scan lets the lowest index win.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      w_any_inv = 1'b0;
      w_inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!w_row[w].valid) begin
            w_any_inv = 1'b1;
            w_inv_way = WAY_W'(w);
         end
         if (w_row[w].valid && (w_row[w].tag == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
   end

   // Free ways are always preferred over evicting a live line.
   assign w_victim = w_any_inv ? w_inv_way : w_plru_victim;
   assign w_touch  = w_hit ? w_hit_way : w_victim;

   plru_tree #(.WAYS(WAYS)) u_plru (
      .i_tree   (w_tree),
      .i_touch  (w_touch),
      .o_victim (w_plru_victim),
      .o_tree   (w_tree_nxt)
   );

   // A flush request in the same cycle takes priority over any request.
   assign w_ready  = (r_state == IDLE) && !bus.flush_start;
   assign w_accept = bus.req_valid && w_ready;

   assign bus.req_ready        = w_ready;
   assign bus.busy             = r_busy;
   assign bus.rsp_valid        = r_rsp_valid;
   assign bus.rsp_hit          = r_rsp_hit;
   assign bus.rsp_way          = r_rsp_way;
   assign bus.rsp_victim       = r_rsp_victim;
   assign bus.rsp_victim_dirty = r_rsp_dirty;

   // Flush FSM, request execution and registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_hit    <= 1'b0;
         r_rsp_way    <= '0;
         r_rsp_victim <= '0;
         r_rsp_dirty  <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            r_plru[s] <= '0;
            for (int w = 0; w < WAYS; w++) r_ways[s][w].valid <= 1'b0;
         end
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.flush_start) begin
                  r_state <= FLUSH;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end else if (w_accept) begin
                  r_rsp_valid  <= 1'b1;
                  r_rsp_hit    <= w_hit;
                  r_rsp_way    <= w_touch;
                  r_rsp_victim <= w_victim;
                  r_rsp_dirty  <= !w_any_inv;
                  case (bus.req_op)
                     OP_FILL: begin
                        // Hit rewrites in place, so duplicates never arise.
                        r_ways[bus.req_set][w_touch] <= way_ent_t'{valid: 1'b1, tag: w_tag};
                        r_plru[bus.req_set]          <= w_tree_nxt;
                     end
                     OP_INVAL: begin
                        if (w_hit) r_ways[bus.req_set][w_hit_way].valid <= 1'b0;
                     end
                     default: begin
                        // LOOKUP and the reserved code: only a hit refreshes recency.
                        if (w_hit) r_plru[bus.req_set] <= w_tree_nxt;
                     end
                  endcase
               end
            end
            FLUSH: begin
               r_plru[r_cnt] <= '0;
               for (int w = 0; w < WAYS; w++) r_ways[r_cnt][w].valid <= 1'b0;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == SET_W'(SETS - 1)) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/assoc_tag_array.md
Name: assoc_tag_array

Overview:
- Parametrised N-way set-associative tag/metadata store with tree pseudo-LRU replacement. Next generation of the 2-way, 64-set tag array.
- Adds configurable sets/ways/tag width, an explicit request/response handshake, an invalidate operation and a sequenced flush.
- Sits beside the cache data array. The cache controller issues lookups, fills and invalidates, and uses the returned way and victim to steer the data array.

Parameters:
- SETS, 64, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; power of 2, 2..8.
- TAG_W, 6, tag width in bits.
- SET_W, log2(SETS), derived; not overridable.
- WAY_W, log2(WAYS), derived; not overridable.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_op  in  2  operation: 00 LOOKUP, 01 FILL, 10 INVAL; 11 reserved, treated as LOOKUP.
- req_set  in  SET_W  set index.
- req_tag  in  TAG_W  tag to compare or write.
- flush_start  in  1  start a full-array flush.
- busy  out  1  flush in progress.
- rsp_valid  out  1  response valid; one-cycle pulse.
- rsp_hit  out  1  tag matched a valid way.
- rsp_way  out  WAY_W  way that hit or was written.
- rsp_victim  out  WAY_W  replacement candidate for req_set.
- rsp_victim_dirty  out  1  victim way held a valid line before this request (eviction needed).

Behaviour:
- Storage per set: WAYS x {valid, tag} plus WAYS-1 tree-PLRU bits. All are flops; no memory macro.
- Reset: all valid bits and PLRU bits are 0; FSM goes to IDLE. Outputs after reset: busy=0, req_ready=1, rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_victim=0, rsp_victim_dirty=0.
- Accept: a request is accepted when req_valid & req_ready. Array state updates at that clock edge.
- Response timing: the response is registered and appears the next cycle with rsp_valid=1. Latency is 1, throughput 1 per cycle.
- Response hold: rsp_* outputs hold their values until the next response; only rsp_valid drops.
- Hit: some way w has valid=1 and a tag equal to req_tag. The tag array never holds duplicates, so at most one way hits.
- Victim select (evaluated at accept):
  - If any way is invalid, the victim is the lowest-index invalid way and rsp_victim_dirty=0.
  - Otherwise the victim is the PLRU tree victim and rsp_victim_dirty=1.
- PLRU update (touch w): set the tree bits on w's path so they point away from w.
- LOOKUP:
  - Hit: rsp_hit=1, rsp_way=w, touch w.
  - Miss: rsp_hit=0, rsp_way=victim, no state change.
  - rsp_victim and rsp_victim_dirty are reported in both cases.
- FILL:
  - Hit: rewrite way w (no duplicate), touch w, rsp_hit=1.
  - Miss: write {1, req_tag} into the victim way, touch it, rsp_hit=0, rsp_way=victim.
  - rsp_victim and rsp_victim_dirty always report the pre-fill state.
- INVAL:
  - Hit: clear valid of way w, PLRU bits unchanged, rsp_hit=1, rsp_way=w.
  - Miss: no change, rsp_hit=0.
- Back-to-back: a request accepted in cycle n+1 sees all updates from the request accepted in cycle n, including same-set and same-tag cases.
- Flush FSM, states IDLE and FLUSH:
  - IDLE -> FLUSH on flush_start. Set counter loads 0, busy=1, req_ready=0.
  - In FLUSH, each cycle clears the valid and PLRU bits of set[counter] and increments the counter.
  - After clearing set SETS-1, return to IDLE. Total is exactly SETS cycles with busy=1.
  - flush_start while in FLUSH is ignored.
  - No rsp_valid is produced during a flush.
- Simultaneous events:
  - flush_start and req_valid in the same IDLE cycle: flush wins, the request is not accepted (req_ready=0 that cycle), and the requester must hold its request.
  - rst asserted mid-flush or mid-response: full reset; no pending response is emitted.
- Wrap-around: the flush counter is SET_W bits. Termination is on counter==SETS-1, not on overflow.

Decomposition:
- Package assoc_tag_pkg holds:
  - op encodings OP_LOOKUP, OP_FILL, OP_INVAL;
  - the FSM state typedef (IDLE, FLUSH);
  - the way-entry struct {valid, tag}.
- Sub-module plru_tree, parametrised by WAYS, purely combinational:
  - inputs: tree bits, touch way;
  - outputs: victim way, updated tree bits.
- The top level instantiates plru_tree once, indexed by req_set.

Test Plan:
- Reset, then LOOKUP set 5 tag 0x2A -> next cycle rsp_valid=1, rsp_hit=0, rsp_victim=0, rsp_victim_dirty=0.
- WAYS=4: FILL set 3 tags 0x01,0x02,0x03,0x04 back-to-back -> rsp_way 0,1,2,3. Then LOOKUP 0x01 (hit, way 0), then FILL 0x05 -> PLRU victim way 2, rsp_victim_dirty=1.
- FILL set 7 tag 0x11 twice -> second response rsp_hit=1 with the same way; LOOKUP 0x11 hits exactly one way.
- INVAL set 7 tag 0x11 -> rsp_hit=1. Following LOOKUP 0x11 -> miss, and rsp_victim is the freed way with rsp_victim_dirty=0.
- After fills, pulse flush_start together with req_valid -> request not accepted; busy=1 for exactly 64 cycles; afterwards every set misses with rsp_victim=0.
- Assert rst at flush cycle 20 -> next cycle busy=0, req_ready=1, all sets invalid, no rsp_valid pulse.
